// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// Build option: MC_CTRL_JAL_EN adds the JAL state and jal opcode decode.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
`ifdef MC_CTRL_JAL_EN
    BEQ      = 4'd9,
    JAL      = 4'd10
`else
    BEQ      = 4'd9
`endif
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_imm_src_dec.sv
// Immediate-type decoder: purely a function of the opcode field.
// Build option: MC_CTRL_JAL_EN enables the J-type (11) result for jal.
module imm_src_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] immSrc
);

  // opcode -> immediate format; unknown opcodes default to I-type
  always_comb begin
    immSrc = IMM_I;
    case (op)
      OP_SW:  immSrc = IMM_S;
      OP_BEQ: immSrc = IMM_B;
`ifdef MC_CTRL_JAL_EN
      OP_JAL: immSrc = IMM_J;
`endif
      default: immSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core.
// Build option: MC_CTRL_JAL_EN adds the JAL state and jal decode; without it
// jal is reported as an illegal instruction.
//
// state    | meaning
// ---------+----------------------------------------------
// FETCH    | read instr at PC into IR, PC <= PC + 4
// DECODE   | read regs, branch target -> ALUOut, dispatch
// MEMADR   | rs1 + imm address for lw/sw
// MEMREAD  | read memory at ALUOut
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to memory at ALUOut
// EXECUTER | register-register ALU op
// EXECUTEI | register-immediate ALU op
// ALUWB    | write ALUOut to rd
// BEQ      | compare rs1/rs2, take branch on zero
// JAL      | rd link value (oldPC + 4), PC <= target
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       regWrite,
  output logic [1:0] immSrc,
  output logic       illegalInstr
);

  state_t state_q;
  state_t state_d;
  logic   pc_update;
  logic   branch;

  imm_src_dec u_imm_src_dec (
    .op     (op),
    .immSrc (immSrc)
  );

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  // next-state and Moore output decode; pcWrite folds in the branch outcome
  always_comb begin
    state_d      = FETCH;
    pc_update    = 1'b0;
    branch       = 1'b0;
    adrSrc       = 1'b0;
    memWrite     = 1'b0;
    irWrite      = 1'b0;
    resultSrc    = RES_ALUOUT;
    aluSrcA      = SRCA_PC;
    aluSrcB      = SRCB_RS2;
    aluOp        = ALUOP_ADD;
    regWrite     = 1'b0;
    illegalInstr = 1'b0;

    case (state_q)
      FETCH: begin
        irWrite   = 1'b1;
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURESULT;
        pc_update = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:       state_d = JAL;
`endif
          default: begin
            state_d      = FETCH;
            illegalInstr = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        if (op == OP_LW)      state_d = MEMREAD;
        else if (op == OP_SW) state_d = MEMWRITE;
        else                  state_d = FETCH;
      end
      MEMREAD: begin
        resultSrc = RES_ALUOUT;
        adrSrc    = 1'b1;
        state_d   = MEMWB;
      end
      MEMWB: begin
        resultSrc = RES_DATA;
        regWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        resultSrc = RES_ALUOUT;
        adrSrc    = 1'b1;
        memWrite  = 1'b1;
        state_d   = FETCH;
      end
      EXECUTER: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        aluOp   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        resultSrc = RES_ALUOUT;
        regWrite  = 1'b1;
        state_d   = FETCH;
      end
      BEQ: begin
        aluSrcA   = SRCA_RS1;
        aluSrcB   = SRCB_RS2;
        aluOp     = ALUOP_SUB;
        resultSrc = RES_ALUOUT;
        branch    = 1'b1;
        state_d   = FETCH;
      end
`ifdef MC_CTRL_JAL_EN
      JAL: begin
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_FOUR;
        aluOp     = ALUOP_ADD;
        resultSrc = RES_ALUOUT;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
`endif
      default: state_d = FETCH;
    endcase

    pcWrite = pc_update | (branch & zero);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model predicts
// every cycle's outputs from the opcode, the step within the instruction and
// the zero flag; directed instructions first, then randomized ones.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegalInstr;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp, immSrc;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 1;          // model: step (1-based) within current instruction
  logic [15:0] tr [1:8];     // outputs seen during the last instruction

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .regWrite(regWrite), .immSrc(immSrc), .illegalInstr(illegalInstr)
  );

  always #5 clk = ~clk;

  // packed layout: pcW adr memW irW res[2] A[2] B[2] aluOp[2] regW imm[2] ill
  function automatic logic [15:0] pack_out(logic pcw, logic adr, logic mw, logic irw,
      logic [1:0] res, logic [1:0] a, logic [1:0] b, logic [1:0] ao, logic rw,
      logic [1:0] imm, logic ill);
    return {pcw, adr, mw, irw, res, a, b, ao, rw, imm, ill};
  endfunction

  function automatic bit jal_on();
`ifdef MC_CTRL_JAL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int instr_len(logic [6:0] o);
    if (o == OP_LW) return 5;
    if (o == OP_SW || o == OP_R || o == OP_I) return 4;
    if (o == OP_BEQ) return 3;
    if (o == OP_JAL && jal_on()) return 4;
    return 2;
  endfunction

  function automatic logic [1:0] exp_imm(logic [6:0] o);
    if (o == OP_SW) return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL && jal_on()) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [15:0] exp_out(logic [6:0] o, int step, logic z);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, a, b, ao;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    res = 0; a = 0; b = 0; ao = 0;
    if (step == 1) begin
      irw = 1; b = 2'b10; res = 2'b10; pcw = 1;
    end else if (step == 2) begin
      a = 2'b01; b = 2'b01; ill = (instr_len(o) == 2);
    end else if (o == OP_LW || o == OP_SW) begin
      if (step == 3) begin a = 2'b10; b = 2'b01; end
      else if (step == 4) begin adr = 1; mw = (o == OP_SW); end
      else begin res = 2'b01; rw = 1; end
    end else if (o == OP_R || o == OP_I) begin
      if (step == 3) begin a = 2'b10; b = (o == OP_I) ? 2'b01 : 2'b00; ao = 2'b10; end
      else rw = 1;
    end else if (o == OP_BEQ) begin
      a = 2'b10; ao = 2'b01; pcw = z;
    end else begin
      if (step == 3) begin a = 2'b01; b = 2'b10; pcw = 1; end
      else rw = 1;
    end
    return pack_out(pcw, adr, mw, irw, res, a, b, ao, rw, exp_imm(o), ill);
  endfunction

  // called #1 after a rising edge: drive this cycle's inputs, check, advance
  task automatic step_cycle(input logic r, input logic z, input logic [6:0] o);
    logic [15:0] act, exp;
    op = o; zero = z; reset = r;
    #1;
    act = pack_out(pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
                   aluOp, regWrite, immSrc, illegalInstr);
    exp = exp_out(o, k, z);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle_outputs t=%0t op=%b step=%0d zero=%b actual=%h expected=%h",
               $time, o, k, z, act, exp);
    end
    tr[k] = act;
    if (r || k >= instr_len(o)) k = 1;
    else k++;
    @(posedge clk); #1;
  endtask

  // zsel: 0/1 fixed zero, 2 random each cycle; rst_step: 0 none, else assert there
  task automatic run_instr(input logic [6:0] o, input int zsel, input int rst_step);
    for (int s = 1; s <= instr_len(o); s++) begin
      logic z;
      z = (zsel == 2) ? 1'($urandom_range(1)) : 1'(zsel);
      step_cycle(s == rst_step, z, o);
      if (s == rst_step) break;
    end
  endtask

  task automatic pin(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  logic [6:0] ops [6];
  logic [6:0] ro;

  initial begin
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
    ops[3] = OP_I;  ops[4] = OP_BEQ; ops[5] = OP_JAL;
    reset = 1'b1; op = OP_LW; zero = 1'b0;
    @(posedge clk); #1;
    k = 1;
    step_cycle(1'b1, 1'b0, OP_LW);
    step_cycle(1'b1, 1'b0, OP_LW);
    pin("reset_fetch_irWrite", int'(tr[1][12]), 1);
    pin("reset_fetch_pcWrite", int'(tr[1][15]), 1);

    run_instr(OP_LW, 0, 0);
    pin("lw_c5_regWrite", int'(tr[5][3]), 1);
    pin("lw_c5_resultSrc", int'(tr[5][11:10]), 1);
    pin("lw_c4_regWrite", int'(tr[4][3]), 0);

    run_instr(OP_SW, 0, 0);
    pin("sw_c4_memWrite", int'(tr[4][13]), 1);
    pin("sw_c4_adrSrc", int'(tr[4][14]), 1);

    run_instr(OP_BEQ, 1, 0);
    pin("beq_z1_pcWrite", int'(tr[3][15]), 1);
    pin("beq_z1_aluOp", int'(tr[3][5:4]), 1);
    run_instr(OP_BEQ, 0, 0);
    pin("beq_z0_pcWrite", int'(tr[3][15]), 0);

    run_instr(OP_R, 0, 0);
    pin("r_exec_aluSrcB", int'(tr[3][7:6]), 0);
    pin("r_exec_aluOp", int'(tr[3][5:4]), 2);
    run_instr(OP_I, 0, 0);
    pin("i_exec_aluSrcB", int'(tr[3][7:6]), 1);
    pin("i_aluwb_regWrite", int'(tr[4][3]), 1);

    run_instr(7'b1111111, 0, 0);
    pin("illegal_decode_pulse", int'(tr[2][0]), 1);
    pin("illegal_fetch_quiet", int'(tr[1][0]), 0);
    run_instr(OP_JAL, 0, 0);
    pin("jal_decode_illegal", int'(tr[2][0]), jal_on() ? 0 : 1);

    run_instr(OP_SW, 0, 3);      // reset during MEMADR of a sw
    run_instr(OP_LW, 1, 0);

    for (int i = 0; i < 400; i++) begin
      int rs;
      ro = ($urandom_range(5) == 0) ? 7'($urandom) : ops[$urandom_range(5)];
      rs = ($urandom_range(7) == 0) ? int'($urandom_range(instr_len(ro), 1)) : 0;
      run_instr(ro, 2, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
